// File: rtl/arith_arbiter.sv
// Round-robin scheduler that shares one registered signed arithmetic unit between two
// requesters, screens divide-by-zero before issue and returns results on a valid/ready channel.
module arith_arbiter #(
  parameter int in_data_width  = 16,
  parameter int out_data_width = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [1:0]                req0_fun,
  input  logic [in_data_width-1:0]  req0_a,
  input  logic [in_data_width-1:0]  req0_b,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [1:0]                req1_fun,
  input  logic [in_data_width-1:0]  req1_a,
  input  logic [in_data_width-1:0]  req1_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [out_data_width-1:0] rsp_data,
  output logic                      rsp_carry,
  output logic                      rsp_err,
  output logic [in_data_width-1:0]  alu_a,
  output logic [in_data_width-1:0]  alu_b,
  output logic [1:0]                alu_fun,
  output logic                      arith_enable,
  input  logic [out_data_width-1:0] arith_out,
  input  logic                      carry_out,
  input  logic                      arith_flag,
  output logic                      busy,
  output logic [15:0]               op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic [in_data_width-1:0]  alu_a_q, alu_a_d;
  logic [in_data_width-1:0]  alu_b_q, alu_b_d;
  logic [1:0]                alu_fun_q, alu_fun_d;
  logic                      arith_enable_q, arith_enable_d;
  logic                      rsp_id_q, rsp_id_d;
  logic [out_data_width-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_carry_q, rsp_carry_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [15:0]               op_count_q, op_count_d;

  logic                      grant;
  logic                      grant_valid;
  logic                      in_idle;
  logic [1:0]                sel_fun;
  logic [in_data_width-1:0]  sel_a;
  logic [in_data_width-1:0]  sel_b;
  logic                      div_zero;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    sel_fun  = grant ? req1_fun : req0_fun;
    sel_a    = grant ? req1_a : req0_a;
    sel_b    = grant ? req1_b : req0_b;
    div_zero = (sel_fun == 2'b11) && (sel_b == '0);
  end

  assign in_idle    = (state_q == IDLE);
  // Readies are gated by reset so nothing appears accepted while reset is held.
  assign req0_ready = rst & in_idle & grant_valid & ~grant;
  assign req1_ready = rst & in_idle & grant_valid & grant;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_fun_d      = alu_fun_q;
    arith_enable_d = arith_enable_q;
    rsp_id_d       = rsp_id_q;
    rsp_data_d     = rsp_data_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_err_d      = rsp_err_q;
    op_count_d     = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant;
          rsp_id_d     = grant;
          if (div_zero) begin
            rsp_data_d  = '0;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            alu_a_d        = sel_a;
            alu_b_d        = sel_b;
            alu_fun_d      = sel_fun;
            arith_enable_d = 1'b1;
            state_d        = ISSUE;
          end
        end
      end
      ISSUE: begin
        arith_enable_d = 1'b0;
        state_d        = WAIT;
      end
      WAIT: begin
        // The unit's registered outputs reflect the issued operands in this cycle.
        rsp_data_d  = arith_out;
        rsp_carry_d = carry_out;
        rsp_err_d   = ~arith_flag;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_fun_q      <= 2'b00;
      arith_enable_q <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_data_q     <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      op_count_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_fun_q      <= alu_fun_d;
      arith_enable_q <= arith_enable_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_err_q      <= rsp_err_d;
      op_count_q     <= op_count_d;
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_err      = rsp_err_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_fun      = alu_fun_q;
  assign arith_enable = arith_enable_q;
  assign busy         = ~in_idle;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_arith_arbiter.sv
// Bench for arith_arbiter: a behavioural registered arithmetic unit, a vector table,
// directed multi-cycle sequences and a randomized run against a cycle-level reference model.
module tb_arith_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_fun = 2'b00, req1_fun = 2'b00;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_fun;
  logic        arith_enable;
  logic [31:0] arith_out;
  logic        carry_out, arith_flag;
  logic        busy;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  arith_arbiter #(.in_data_width(16), .out_data_width(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .arith_enable(arith_enable),
    .arith_out(arith_out), .carry_out(carry_out), .arith_flag(arith_flag),
    .busy(busy), .op_count(op_count)
  );

  // Signed arithmetic as the unit defines it: 32-bit result, division truncates toward zero.
  function automatic logic [31:0] ref_op(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
    int x;
    int y;
    x = int'($signed(a));
    y = int'($signed(b));
    case (f)
      2'b00: return 32'(x + y);
      2'b01: return 32'(x - y);
      2'b10: return 32'(x * y);
      default: return (y == 0) ? 32'd0 : 32'(x / y);
    endcase
  endfunction

  // Registered unit: outputs are meaningful only in the cycle after an enable, garbage otherwise.
  logic        flag_ctl = 1'b1;
  logic [31:0] unit_r;
  assign unit_r = ref_op(alu_fun, alu_a, alu_b);
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      arith_out  <= '0;
      carry_out  <= 1'b0;
      arith_flag <= 1'b0;
    end else if (arith_enable) begin
      arith_out  <= unit_r;
      carry_out  <= unit_r[16];
      arith_flag <= flag_ctl;
    end else begin
      arith_out  <= $urandom;
      carry_out  <= 1'($urandom);
      arith_flag <= 1'b0;
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int exp_opc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_opc = 0;
  endtask

  // Single operation from one requester with rsp_ready high; starts and ends 1 unit after an edge.
  task automatic do_op(input int id, input logic [1:0] fun, input logic [15:0] a, input logic [15:0] b,
                       output logic rdy, output int lat, output int en, output logic rid,
                       output logic [31:0] rdata, output logic rerr, output logic rcarry);
    int w;
    rsp_ready = 1'b1;
    if (id == 0) begin
      req0_fun = fun; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_fun = fun; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    #1;
    w = 0;
    while (!((id == 0) ? req0_ready : req1_ready) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    rdy = (id == 0) ? req0_ready : req1_ready;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    en = 0;
    while (!rsp_valid && lat < 20) begin
      en += int'(arith_enable);
      @(posedge clk); #1; lat++;
    end
    en += int'(arith_enable);
    rid = rsp_id; rdata = rsp_data; rerr = rsp_err; rcarry = rsp_carry;
    @(posedge clk); #1;
    if (lat < 20) exp_opc++;
  endtask

  typedef struct {
    int          id;
    logic [1:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] data;
    logic        err;
    logic        carry;
    int          lat;
    int          en;
  } vec_t;

  vec_t        vecs[9];
  logic        t_rdy, t_rid, t_err, t_carry;
  int          t_lat, t_en;
  logic [31:0] t_data;
  int          cnt, got;
  int          ids[3];
  logic [31:0] ds[3];
  // random-phase model state
  bit          have, dz, v0, v1, last, exp_idle, e_r0, e_r1, e_v;
  int          idle_from, it_acc, it_due, it_id, ntx;
  logic [31:0] it_data;
  logic        it_err, it_carry;
  logic [1:0]  f;
  logic [15:0] ra, rb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 2'b00, 16'd100, 16'(-30), 32'd70, 1'b0, 1'b0, 3, 1};
    vecs[1] = '{1, 2'b01, 16'd5, 16'd9, 32'hFFFF_FFFC, 1'b0, 1'b1, 3, 1};
    vecs[2] = '{0, 2'b10, 16'd300, 16'd200, 32'd60000, 1'b0, 1'b0, 3, 1};
    vecs[3] = '{0, 2'b11, 16'(-7), 16'd2, 32'hFFFF_FFFD, 1'b0, 1'b1, 3, 1};
    vecs[4] = '{1, 2'b11, 16'd7, 16'd0, 32'd0, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{1, 2'b10, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0, 3, 1};
    vecs[6] = '{0, 2'b11, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0, 1'b0, 3, 1};
    vecs[7] = '{1, 2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 3, 1};
    vecs[8] = '{0, 2'b11, 16'd9, 16'(-4), 32'hFFFF_FFFE, 1'b0, 1'b1, 3, 1};

    // Reset state, with requests pending to show readies are held low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    chk("rst_req0_ready", 32'(req0_ready), 0);
    chk("rst_req1_ready", 32'(req1_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_arith_enable", 32'(arith_enable), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_count", 32'(op_count), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].id, vecs[i].fun, vecs[i].a, vecs[i].b, t_rdy, t_lat, t_en, t_rid, t_data, t_err, t_carry);
      $display("vec %0d: id=%0d fun=%0d a=%0d b=%0d -> data=%0d err=%0b carry=%0b lat=%0d en=%0d",
               i, vecs[i].id, vecs[i].fun, $signed(vecs[i].a), $signed(vecs[i].b),
               $signed(t_data), t_err, t_carry, t_lat, t_en);
      chk($sformatf("vec%0d_ready", i), 32'(t_rdy), 1);
      chk($sformatf("vec%0d_latency", i), 32'(t_lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_enable_pulses", i), 32'(t_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d_rsp_id", i), 32'(t_rid), 32'(vecs[i].id));
      chk($sformatf("vec%0d_rsp_data", i), t_data, vecs[i].data);
      chk($sformatf("vec%0d_rsp_err", i), 32'(t_err), 32'(vecs[i].err));
      chk($sformatf("vec%0d_rsp_carry", i), 32'(t_carry), 32'(vecs[i].carry));
      chk($sformatf("vec%0d_busy_after", i), 32'(busy), 0);
      chk($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(exp_opc));
    end

    // Unit reports an invalid result: data passes through, error flagged.
    flag_ctl = 1'b0;
    do_op(1, 2'b00, 16'd3, 16'd4, t_rdy, t_lat, t_en, t_rid, t_data, t_err, t_carry);
    flag_ctl = 1'b1;
    $display("flag_low: data=%0d err=%0b", $signed(t_data), t_err);
    chk("flag_low_data", t_data, 32'd7);
    chk("flag_low_err", 32'(t_err), 1);

    // Backpressure: response held for 5 cycles while both requesters wait.
    rsp_ready = 1'b0;
    req0_fun = 2'b00; req0_a = 16'd11; req0_b = 16'd22; req0_valid = 1'b1;
    #1;
    cnt = 0;
    while (!req0_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("bp_accept", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req1_fun = 2'b01; req1_a = 16'd1; req1_b = 16'd1; req1_valid = 1'b1;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("bp_rsp_valid_rise", 32'(rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_data", rsp_data, 32'd33);
      chk("bp_hold_id", 32'(rsp_id), 0);
      chk("bp_hold_err", 32'(rsp_err), 0);
      chk("bp_hold_readies", {30'd0, req1_ready, req0_ready}, 0);
      chk("bp_hold_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    exp_opc++;
    @(posedge clk); #1;
    $display("backpressure: data=33 released, op_count=%0d", op_count);
    chk("bp_idle_after", 32'(busy), 0);
    chk("bp_op_count", 32'(op_count), 32'(exp_opc));
    @(posedge clk); #1;
    chk("bp_op_count_once", 32'(op_count), 32'(exp_opc));

    // Contention after reset: req0 wins the first tie, then alternation.
    do_reset();
    req0_fun = 2'b10; req0_a = 16'd300; req0_b = 16'd200;
    req1_fun = 2'b01; req1_a = 16'd5; req1_b = 16'd9;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    got = 0; cnt = 0;
    for (int k = 0; k < 3; k++) begin ids[k] = -1; ds[k] = 32'hDEAD_BEEF; end
    while (got < 3 && cnt < 60) begin
      @(posedge clk); #1; cnt++;
      if (rsp_valid) begin
        ids[got] = int'(rsp_id); ds[got] = rsp_data; got++;
        $display("contention rsp %0d: id=%0d data=%0d", got, rsp_id, $signed(rsp_data));
        if (got == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_count", 32'(got), 3);
    chk("cont_id0", 32'(ids[0]), 0);
    chk("cont_id1", 32'(ids[1]), 1);
    chk("cont_id2", 32'(ids[2]), 0);
    chk("cont_data0", ds[0], 32'd60000);
    chk("cont_data1", ds[1], 32'hFFFF_FFFC);
    chk("cont_data2", ds[2], 32'd60000);
    @(posedge clk); #1;
    chk("cont_op_count", 32'(op_count), 3);

    // Reset during WAIT aborts the operation.
    req0_fun = 2'b00; req0_a = 16'd1; req0_b = 16'd2; req0_valid = 1'b1;
    #1;
    chk("midrst_accept", 32'(req0_ready), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_before", 32'(busy), 1);
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_alu_a", 32'(alu_a), 0);
    chk("midrst_alu_fun", 32'(alu_fun), 0);
    chk("midrst_op_count", 32'(op_count), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; cnt += int'(rsp_valid); end
    chk("midrst_no_stale_rsp", 32'(cnt), 0);
    chk("midrst_op_count_after", 32'(op_count), 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("midrst_tie_req0", 32'(req0_ready), 1);
    chk("midrst_tie_req1", 32'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Randomized run against a cycle-level model.
    do_reset();
    have = 0; idle_from = 0; last = 1; ntx = 0;
    it_acc = 0; it_due = 0; it_id = 0; dz = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      v0 = ($urandom_range(0, 9) < 5);
      v1 = ($urandom_range(0, 9) < 5);
      req0_valid = v0; req1_valid = v1;
      req0_fun = 2'($urandom_range(0, 3)); req1_fun = 2'($urandom_range(0, 3));
      req0_a = 16'($urandom); req1_a = 16'($urandom);
      req0_b = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
      req1_b = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_idle = !have && (c >= idle_from);
      e_r0 = exp_idle && v0 && (!v1 || last);
      e_r1 = exp_idle && v1 && (!v0 || !last);
      e_v  = have && (c >= it_due);
      chk("rnd_req0_ready", 32'(req0_ready), 32'(e_r0));
      chk("rnd_req1_ready", 32'(req1_ready), 32'(e_r1));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(e_v));
      chk("rnd_arith_enable", 32'(arith_enable), 32'(have && !dz && (c == it_acc + 1)));
      chk("rnd_busy", 32'(busy), 32'(!exp_idle));
      chk("rnd_op_count", 32'(op_count), 32'(16'(exp_opc)));
      if (e_v && rsp_ready) begin
        chk("rnd_rsp_id", 32'(rsp_id), 32'(it_id));
        chk("rnd_rsp_data", rsp_data, it_data);
        chk("rnd_rsp_err", 32'(rsp_err), 32'(it_err));
        chk("rnd_rsp_carry", 32'(rsp_carry), 32'(it_carry));
        ntx++;
        $display("rnd txn %0d: id=%0d data=%0d err=%0b carry=%0b", ntx, rsp_id, $signed(rsp_data), rsp_err, rsp_carry);
        have = 0; idle_from = c + 1; exp_opc++;
      end
      if (e_r0 || e_r1) begin
        f  = e_r1 ? req1_fun : req0_fun;
        ra = e_r1 ? req1_a : req0_a;
        rb = e_r1 ? req1_b : req0_b;
        dz = (f == 2'b11) && (rb == 16'd0);
        it_id    = e_r1 ? 1 : 0;
        it_data  = dz ? 32'd0 : ref_op(f, ra, rb);
        it_err   = dz;
        it_carry = dz ? 1'b0 : it_data[16];
        it_acc   = c;
        it_due   = c + (dz ? 1 : 3);
        have     = 1;
        last     = e_r1;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rnd_drained", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arith_arbiter.md
# arith_arbiter

Two-requester scheduler that shares one registered signed arithmetic unit (add/sub/mul/div, 16-bit operands, 32-bit result) between requesters. It arbitrates round-robin and issues exactly one one-cycle `arith_enable` pulse per accepted operation. It captures the unit's registered result and returns it on a valid/ready response channel. It sits between the command sources and the arithmetic unit, screens divide-by-zero before issue and counts completed operations.

## Interface
- `in_data_width`, default 16: operand width, shared by requests and unit.
- `out_data_width`, default 32: result width.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when ready and valid are both 1.
- `req0_fun`, `req1_fun` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in `in_data_width`: signed operands.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_id` out 1: requester index of the response.
- `rsp_data` out `out_data_width`: signed result.
- `rsp_carry` out 1: unit carry (result bit `in_data_width`).
- `rsp_err` out 1: divide-by-zero, or `arith_flag` low at capture.
- `alu_a`, `alu_b` out `in_data_width`: operands to the unit.
- `alu_fun` out 2: function select to the unit.
- `arith_enable` out 1: unit enable.
- `arith_out` in `out_data_width`: unit registered result.
- `carry_out` in 1: unit registered carry.
- `arith_flag` in 1: unit registered valid flag.
- `busy` out 1: state is not IDLE.
- `op_count` out 16: responses delivered since reset; wraps at 65535 to 0.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant is combinational. If only one request is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - `reqN_ready` = (state == IDLE) and grant == N. Both readies are 0 in every other state.
- **Accept edge (valid and ready)**
  - Latch `fun`, `a`, `b` and id, and update `last_grant`.
  - Divide-by-zero (`fun` == 11 and `b` == 0): go to RESP with `rsp_data` = 0, `rsp_carry` = 0, `rsp_err` = 1. The unit is never enabled.
  - Otherwise: register `alu_a`, `alu_b`, `alu_fun` and `arith_enable` = 1, then go to ISSUE.
- **ISSUE** (one cycle): `arith_enable` is 1. At the edge ending ISSUE, `arith_enable` goes to 0 and the state goes to WAIT. `alu_a`, `alu_b`, `alu_fun` hold their values.
- **WAIT** (one cycle): the unit's registered outputs are valid.
  - At the edge, capture `rsp_data` = `arith_out`, `rsp_carry` = `carry_out`, `rsp_err` = !`arith_flag`.
  - Go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id`, `rsp_data`, `rsp_carry` and `rsp_err` stay stable until the handshake.
  - On `rsp_valid` and `rsp_ready`: go to IDLE and increment `op_count` (modulo 2^16).
  - No request is accepted on the same edge.
- The unit computes the arithmetic; this block passes operands and results unmodified.
  - Results are signed two's complement.
  - Division truncates toward zero.
  - The product is full 32-bit.

## Timing
- Reset (asynchronous, active-low): values are
  - state IDLE, `last_grant` 1.
  - All outputs 0: `req*_ready`, `rsp_*`, `alu_a`, `alu_b`, `alu_fun`, `arith_enable`, `busy`, `op_count`.
- Latency from accept edge to first cycle of `rsp_valid`:
  - Normal operation: 3 cycles (ISSUE, WAIT, then RESP).
  - Divide-by-zero: 1 cycle.
- Minimum accept-to-accept spacing: 4 cycles normal, 2 cycles divide-by-zero, plus cycles spent waiting for `rsp_ready`.
- `arith_enable` is high for exactly one cycle per normal operation and never outside ISSUE.
- Reset asserted mid-operation (any state) aborts the operation. No response is produced for it and `op_count` is not incremented.
- `rsp_ready` held high in advance: RESP lasts exactly one cycle.
- A request dropping `valid` before acceptance has no effect. A requester is not obliged to hold a request it withdraws.

## Test plan
- **Single add:** req0 `fun`=00, `a`=100, `b`=-30 alone, `rsp_ready`=1.
  - `req0_ready` is 1 in the accept cycle.
  - `arith_enable` pulses for 1 cycle.
  - `rsp_valid` rises 3 cycles after accept with `rsp_id`=0, `rsp_data`=70, `rsp_err`=0.
  - `op_count`=1.
- **Contention:** after reset, both requesters hold valid (req0 mul 300×200, req1 sub 5−9).
  - Responses arrive in order req0, req1, req0.
  - `rsp_data` = 60000, -4, 60000.
- **Divide-by-zero:** req1 `fun`=11, `a`=7, `b`=0.
  - `rsp_valid` 1 cycle after accept with `rsp_err`=1, `rsp_data`=0, `rsp_id`=1.
  - `arith_enable` stays 0 throughout.
- **Signed divide:** req0 `fun`=11, `a`=-7, `b`=2 → `rsp_data`=-3, `rsp_err`=0.
- **Backpressure:** `rsp_ready` held 0 for 5 cycles in RESP.
  - `rsp_*` stay stable, both readies stay 0, `busy`=1.
  - After `rsp_ready`=1: IDLE on the next cycle, `op_count` increments once.
- **Reset mid-operation:** assert `rst`=0 during WAIT.
  - All outputs are 0 immediately.
  - After release, no stale response appears, `op_count`=0, and req0 wins the next tie.
